// File: rtl/seq_match_window_counter.sv
// Counts detector match pulses over fixed WINDOW_LEN-cycle windows and reports each window
// over a valid/ready handshake. Optional feature macro: SEQ_MATCH_GAP_EN (adds rpt_min_gap).
module seq_match_window_counter #(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             match_in,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic [IDX_W-1:0] rpt_win_idx,
`ifdef SEQ_MATCH_GAP_EN
    output logic [CNT_W-1:0] rpt_min_gap,
`endif
    output logic             win_active,
    output logic             overrun
);

    localparam int CYC_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rpt_valid_q, rpt_valid_d;
    logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
    logic [IDX_W-1:0] rpt_win_idx_q, rpt_win_idx_d;
    logic             overrun_q, overrun_d;

    logic             counting;
    logic             close;
    logic             accept;
    logic [CNT_W-1:0] match_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_active = (state_q == RUN);
    end

    // A window only advances while enabled; dropping en discards the partial window.
    always_comb begin
        counting   = (state_q == RUN) && en;
        close      = counting && (cyc_q == LAST_CYC);
        accept     = rpt_valid_q && rpt_ready;
        match_next = (match_in && (match_cnt_q != CNT_MAX)) ? match_cnt_q + 1'b1 : match_cnt_q;

        cyc_d         = cyc_q;
        match_cnt_d   = match_cnt_q;
        idx_d         = idx_q;
        rpt_valid_d   = rpt_valid_q;
        rpt_count_d   = rpt_count_q;
        rpt_win_idx_d = rpt_win_idx_q;
        overrun_d     = overrun_q;

        if (!counting) begin
            cyc_d       = '0;
            match_cnt_d = '0;
        end else if (close) begin
            cyc_d       = '0;
            match_cnt_d = '0;
            idx_d       = idx_q + 1'b1;
        end else begin
            cyc_d       = cyc_q + 1'b1;
            match_cnt_d = match_next;
        end

        if (accept) begin
            rpt_valid_d = 1'b0;
        end

        // The slot is free if empty or being drained this very edge (back-to-back reload).
        if (close) begin
            if (!rpt_valid_q || accept) begin
                rpt_valid_d   = 1'b1;
                rpt_count_d   = match_next;
                rpt_win_idx_d = idx_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q         <= '0;
            match_cnt_q   <= '0;
            idx_q         <= '0;
            rpt_valid_q   <= 1'b0;
            rpt_count_q   <= '0;
            rpt_win_idx_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            cyc_q         <= cyc_d;
            match_cnt_q   <= match_cnt_d;
            idx_q         <= idx_d;
            rpt_valid_q   <= rpt_valid_d;
            rpt_count_q   <= rpt_count_d;
            rpt_win_idx_q <= rpt_win_idx_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rpt_valid   = rpt_valid_q;
    assign rpt_count   = rpt_count_q;
    assign rpt_win_idx = rpt_win_idx_q;
    assign overrun     = overrun_q;

`ifdef SEQ_MATCH_GAP_EN
    localparam int GAP_W = (CYC_W > CNT_W) ? CYC_W : CNT_W;

    logic [CYC_W-1:0] last_pos_q, last_pos_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] min_gap_q, min_gap_d;
    logic [CNT_W-1:0] rpt_min_gap_q, rpt_min_gap_d;
    logic [GAP_W-1:0] gap_wide;
    logic [CNT_W-1:0] gap_sat;
    logic [CNT_W-1:0] min_next;

    // Gap tracking stays all-ones until a second match in the window provides a distance.
    always_comb begin
        gap_wide = GAP_W'(cyc_q - last_pos_q);
        gap_sat  = (gap_wide > GAP_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(gap_wide);
        min_next = (match_in && seen_q && (gap_sat < min_gap_q)) ? gap_sat : min_gap_q;

        last_pos_d    = last_pos_q;
        seen_d        = seen_q;
        min_gap_d     = min_gap_q;
        rpt_min_gap_d = rpt_min_gap_q;

        if (!counting || close) begin
            last_pos_d = '0;
            seen_d     = 1'b0;
            min_gap_d  = '1;
        end else if (match_in) begin
            last_pos_d = cyc_q;
            seen_d     = 1'b1;
            min_gap_d  = min_next;
        end

        if (close && (!rpt_valid_q || accept)) begin
            rpt_min_gap_d = min_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pos_q    <= '0;
            seen_q        <= 1'b0;
            min_gap_q     <= '1;
            rpt_min_gap_q <= '0;
        end else begin
            last_pos_q    <= last_pos_d;
            seen_q        <= seen_d;
            min_gap_q     <= min_gap_d;
            rpt_min_gap_q <= rpt_min_gap_d;
        end
    end

    assign rpt_min_gap = rpt_min_gap_q;
`endif

endmodule
